// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, hazard controller state and
// stage-control bundle used by the pipeline sequencing logic.
package core_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic pc_redirect;
    } stage_ctl_t;

    // Frozen: nothing moves, nothing is flushed.
    localparam stage_ctl_t CTL_FROZEN = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, pc_redirect: 1'b0
    };

    localparam stage_ctl_t CTL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, pc_redirect: 1'b0
    };

    // Hold PC and IF/ID, push a bubble into ID/EX, let the load proceed.
    localparam stage_ctl_t CTL_BUBBLE = '{
        pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, pc_redirect: 1'b0
    };

    localparam stage_ctl_t CTL_REDIRECT = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, pc_redirect: 1'b1
    };

    function automatic logic load_use_hazard(
        input logic [REG_ADDR_WIDTH-1:0] rs1,
        input logic [REG_ADDR_WIDTH-1:0] rs2,
        input logic                      uses_rs1,
        input logic                      uses_rs2,
        input logic [REG_ADDR_WIDTH-1:0] rd,
        input logic                      mem_read
    );
        logic w_rd_live;
        w_rd_live = mem_read && (rd != '0);
        return w_rd_live && ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: memory freeze, branch redirect/flush,
// load-use bubble insertion and stall/flush performance counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_uses_rs1_i,
    input  logic                      id_uses_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_MemRead_i,
    input  logic                      redirect_valid_i,
    input  logic [DATA_WIDTH-1:0]     redirect_target_i,
    input  logic                      mem_busy_i,
    output logic                      pc_write_o,
    output logic                      if_id_write_o,
    output logic                      id_ex_write_o,
    output logic                      ex_mem_write_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_flush_o,
    output logic                      pc_redirect_o,
    output logic [DATA_WIDTH-1:0]     pc_target_o,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

    localparam logic [2:0] BUBBLE_RELOAD = 3'(LOAD_USE_BUBBLES - 1);

    hazard_state_e          r_state;
    hazard_state_e          r_ret_state;
    logic                   r_pend;
    logic [DATA_WIDTH-1:0]  r_pend_target;
    logic [2:0]             r_bubble_cnt;

    hazard_state_e          w_eff_state;
    logic                   w_hazard;
    logic                   w_redirect;
    logic                   w_bubble;
    stage_ctl_t             w_ctl;

    // While frozen the FSM sits in MEM_WAIT; once busy drops it behaves as the saved state.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

    assign w_hazard = load_use_hazard(id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i,
                                      id_uses_rs2_i, ex_rd_addr_i, ex_MemRead_i);

    assign w_redirect = !mem_busy_i && (redirect_valid_i || r_pend);

    assign w_bubble = !mem_busy_i && !w_redirect &&
                      ((w_eff_state == LU_STALL) || ((w_eff_state == RUN) && w_hazard));

    always_comb begin
        w_ctl = CTL_RUN;
        if (!rst_n || mem_busy_i) begin
            w_ctl = CTL_FROZEN;
        end else if (w_redirect) begin
            w_ctl = CTL_REDIRECT;
        end else if (w_bubble) begin
            w_ctl = CTL_BUBBLE;
        end
    end

    assign pc_write_o     = w_ctl.pc_write;
    assign if_id_write_o  = w_ctl.if_id_write;
    assign id_ex_write_o  = w_ctl.id_ex_write;
    assign ex_mem_write_o = w_ctl.ex_mem_write;
    assign if_id_flush_o  = w_ctl.if_id_flush;
    assign id_ex_flush_o  = w_ctl.id_ex_flush;
    assign pc_redirect_o  = w_ctl.pc_redirect;

    // A fresh redirect in the same cycle supersedes one remembered from a freeze.
    assign pc_target_o = !w_ctl.pc_redirect ? '0 :
                         redirect_valid_i   ? redirect_target_i : r_pend_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_ret_state   <= RUN;
            r_pend        <= 1'b0;
            r_pend_target <= '0;
            r_bubble_cnt  <= 3'd0;
        end else if (mem_busy_i) begin
            if (redirect_valid_i) begin
                r_pend        <= 1'b1;
                r_pend_target <= redirect_target_i;
            end
            if (r_state != MEM_WAIT) begin
                r_ret_state <= r_state;
            end
            r_state <= MEM_WAIT;
        end else if (w_redirect) begin
            r_pend       <= 1'b0;
            r_bubble_cnt <= 3'd0;
            r_state      <= RUN;
            r_ret_state  <= RUN;
        end else if (w_eff_state == LU_STALL) begin
            if (r_bubble_cnt <= 3'd1) begin
                r_bubble_cnt <= 3'd0;
                r_state      <= RUN;
            end else begin
                r_bubble_cnt <= r_bubble_cnt - 3'd1;
                r_state      <= LU_STALL;
            end
            r_ret_state <= RUN;
        end else if (w_hazard && (LOAD_USE_BUBBLES > 1)) begin
            r_bubble_cnt <= BUBBLE_RELOAD;
            r_state      <= LU_STALL;
            r_ret_state  <= RUN;
        end else begin
            r_state     <= RUN;
            r_ret_state <= RUN;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (rst_n && !w_ctl.pc_write),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (w_ctl.pc_redirect),
        .count_o (flush_cnt_o)
    );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It detects load-use hazards between ID and EX, inserts the required bubbles, and flushes IF/ID and ID/EX on a taken branch or jump resolved in EX. It freezes the whole pipeline while data memory is busy and remembers a redirect that arrives during a freeze. It drives the stage-register write enables and flush controls, plus the PC redirect mux, and keeps saturating stall and flush counters for performance analysis.

## Interface
Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  REG_ADDR_WIDTH  rs1 of instruction in ID
- id_rs2_addr_i  in  REG_ADDR_WIDTH  rs2 of instruction in ID
- id_uses_rs1_i  in  1  ID instruction reads rs1
- id_uses_rs2_i  in  1  ID instruction reads rs2
- ex_rd_addr_i  in  REG_ADDR_WIDTH  rd of instruction in EX (0 when no write)
- ex_MemRead_i  in  1  EX instruction is a load
- redirect_valid_i  in  1  EX resolved taken branch/jump this cycle (single-cycle pulse)
- redirect_target_i  in  DATA_WIDTH  target PC for that redirect
- mem_busy_i  in  1  data memory not ready; pipeline must freeze
- pc_write_o  out  1  PC register enable
- if_id_write_o / id_ex_write_o / ex_mem_write_o  out  1 each  stage-register enables
- if_id_flush_o / id_ex_flush_o  out  1 each  load bubble into stage register (overrides data, requires write=1)
- pc_redirect_o  out  1  PC mux selects pc_target_o
- pc_target_o  out  DATA_WIDTH  redirect target
- stall_cycles_o  out  CNT_WIDTH  cycles with pc_write_o=0
- flush_cnt_o  out  CNT_WIDTH  redirects taken

## Operation
- States: RUN, LU_STALL, MEM_WAIT. Internal state: pend (1 b), pend_target (DATA_WIDTH), bubble counter (3 b).
- Per-cycle priority: freeze > redirect > load-use stall > normal.
- Freeze (mem_busy_i=1): all writes 0, all flushes 0, pc_redirect_o=0. If redirect_valid_i=1, latch pend=1 and pend_target=redirect_target_i. Bubble counter holds. Next state is MEM_WAIT. When busy drops, return to the saved state (RUN or LU_STALL).
- Redirect (not busy and (redirect_valid_i or pend)):
  - pc_redirect_o=1.
  - pc_target_o = redirect_valid_i ? redirect_target_i : pend_target (a new pulse wins).
  - All writes 1, if_id_flush_o=1, id_ex_flush_o=1.
  - pend cleared, bubble counter cleared, next state RUN, flush_cnt_o++.
- Load-use (RUN, not busy, no redirect): hazard = ex_MemRead_i & ex_rd_addr_i≠0 & ((id_uses_rs1_i & rs1==rd) | (id_uses_rs2_i & rs2==rd)).
  - On hazard: pc_write_o=0, if_id_write_o=0, id_ex_write_o=1, id_ex_flush_o=1, ex_mem_write_o=1.
  - If LOAD_USE_BUBBLES>1, load counter with LOAD_USE_BUBBLES-1 and enter LU_STALL.
- LU_STALL: same outputs as the hazard case regardless of current inputs. Counter decrements each non-frozen cycle. Return to RUN when it reaches 0 (exit on the cycle the counter is 1).
- Normal: all writes 1, flushes 0, pc_redirect_o=0.
- Counters saturate at all-ones and never wrap. stall_cycles_o counts freeze and load-use cycles. It does not count reset cycles.
- pc_target_o = 0 when pc_redirect_o=0.

## Timing
- All hazard/flush/enable outputs are combinational from current state plus inputs; 0-cycle latency.
- Internal state and counters are registered on posedge clk.
- Reset (rst_n low, asynchronous): state RUN, pend=0, pend_target=0, counter=0, both perf counters 0.
  - While rst_n is low, all enables, flushes and pc_redirect_o are 0; pc_target_o=0.
- Reset asserted mid-stall or mid-freeze discards pend and the bubble count immediately.
- A redirect during LU_STALL aborts the remaining bubbles in the same cycle.
- A redirect during freeze takes effect in the first non-busy cycle.

## Structure
- core_pkg gains hazard_state_e (RUN, LU_STALL, MEM_WAIT). It reuses REG_ADDR_WIDTH and DATA_WIDTH.
- One sub-module, sat_counter (parameter WIDTH; inputs inc_i, clk, rst_n), instantiated twice for the perf counters.

## Test plan
- Load-use: ex_MemRead_i=1, ex_rd=5, id_rs1=5, uses_rs1=1 -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly LOAD_USE_BUBBLES cycles; stall_cycles_o +1 per cycle.
- rd=x0 load with rs1=0, or uses_rs2=0 with rs2 matching -> no stall; all writes 1.
- redirect_valid_i with target 0x0000_0100 while not busy -> pc_redirect=1, pc_target=0x100, both flushes 1 in the same cycle; flush_cnt_o=1.
- redirect pulse (target 0x200) during 3-cycle mem_busy_i -> all enables 0 for 3 cycles, then one cycle with pc_redirect=1, target 0x200.
- LOAD_USE_BUBBLES=3: redirect in 2nd stall cycle -> flush that cycle, RUN next cycle, no third bubble.
- Force counters near all-ones and stall -> counters hold at 0xFFFF_FFFF. Assert rst_n low mid-MEM_WAIT -> all outputs 0 immediately, counters 0.
